// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// master = pipeline side, slave = hazard_stall_unit.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             if_id_uses_rt;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_ex_mem_read, id_ex_rt,
        output if_id_rs, if_id_rt, if_id_uses_rt,
        output branch_taken,
        input  pc_write, if_id_write, id_ex_bubble,
        input  if_id_flush, stall_active, stall_cycles
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt,
        input  if_id_rs, if_id_rt, if_id_uses_rt,
        input  branch_taken,
        output pc_write, if_id_write, id_ex_bubble,
        output if_id_flush, stall_active, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector, stall/flush control and
// saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_unit_if.slave hif
);
    typedef enum logic {RUN, HOLD} state_t;

    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI    = (LOAD_STALL_CYCLES > 1);

    state_t     state, state_n;
    logic [2:0] rem, rem_n;
    logic [CNT_W-1:0] cnt;
    logic       haz;
    logic       stall;

    assign haz = hif.id_ex_mem_read && (hif.id_ex_rt != 5'd0) &&
                 ((hif.id_ex_rt == hif.if_id_rs) ||
                  (hif.if_id_uses_rt && (hif.id_ex_rt == hif.if_id_rt)));

    // Reset masks the stall so the front end free-runs while rst is high.
    assign stall = !rst && ((state == HOLD) || haz);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        unique case (state)
            RUN: begin
                if (haz && MULTI) begin
                    state_n = HOLD;
                    rem_n   = REM_INIT;
                end
            end
            HOLD: begin
                rem_n = rem - 3'd1;
                if (rem == 3'd1) state_n = RUN;
            end
        endcase
    end

    always_comb begin
        hif.pc_write     = !stall;
        hif.if_id_write  = !stall;
        hif.id_ex_bubble = stall;
        hif.stall_active = stall;
        hif.if_id_flush  = !rst && hif.branch_taken && !stall;
        hif.stall_cycles = cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: three configurations share one stimulus stream
// and are checked against a cycle model every cycle.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       mr, urt, br;
    logic [4:0] ert, rs, rt;

    hazard_stall_unit_if #(.CNT_W(16)) hif_d ();
    hazard_stall_unit_if #(.CNT_W(16)) hif_s3 ();
    hazard_stall_unit_if #(.CNT_W(4))  hif_sat ();

    assign hif_d.id_ex_mem_read   = mr;
    assign hif_d.id_ex_rt         = ert;
    assign hif_d.if_id_rs         = rs;
    assign hif_d.if_id_rt         = rt;
    assign hif_d.if_id_uses_rt    = urt;
    assign hif_d.branch_taken     = br;
    assign hif_s3.id_ex_mem_read  = mr;
    assign hif_s3.id_ex_rt        = ert;
    assign hif_s3.if_id_rs        = rs;
    assign hif_s3.if_id_rt        = rt;
    assign hif_s3.if_id_uses_rt   = urt;
    assign hif_s3.branch_taken    = br;
    assign hif_sat.id_ex_mem_read = mr;
    assign hif_sat.id_ex_rt       = ert;
    assign hif_sat.if_id_rs       = rs;
    assign hif_sat.if_id_rt       = rt;
    assign hif_sat.if_id_uses_rt  = urt;
    assign hif_sat.branch_taken   = br;

    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_d (
        .clk(clk), .rst(rst), .hif(hif_d.slave)
    );
    hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_s3 (
        .clk(clk), .rst(rst), .hif(hif_s3.slave)
    );
    hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .hif(hif_sat.slave)
    );

    typedef struct packed {
        logic [2:0][4:0]  ctl;
        logic [2:0][15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   lsc[3]  = '{1, 3, 1};
    int   cmax[3] = '{65535, 65535, 15};
    int   left[3] = '{0, 0, 0};
    int   cnt_m[3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic haz_f();
        return mr && (ert != 5'd0) &&
               ((ert == rs) || (urt && (ert == rt)));
    endfunction

    function automatic logic stall_f(int k);
        return !rst && ((left[k] > 0) || haz_f());
    endfunction

    function automatic logic [4:0] dut_ctl(int k);
        case (k)
            0: return {hif_d.pc_write, hif_d.if_id_write, hif_d.id_ex_bubble,
                       hif_d.if_id_flush, hif_d.stall_active};
            1: return {hif_s3.pc_write, hif_s3.if_id_write, hif_s3.id_ex_bubble,
                       hif_s3.if_id_flush, hif_s3.stall_active};
            default: return {hif_sat.pc_write, hif_sat.if_id_write,
                             hif_sat.id_ex_bubble, hif_sat.if_id_flush,
                             hif_sat.stall_active};
        endcase
    endfunction

    function automatic logic [15:0] dut_cnt(int k);
        case (k)
            0: return hif_d.stall_cycles;
            1: return hif_s3.stall_cycles;
            default: return {12'd0, hif_sat.stall_cycles};
        endcase
    endfunction

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            logic sa, fl;
            sa = stall_f(k);
            fl = !rst && br && !sa;
            e.ctl[k] = {!sa, !sa, sa, fl, sa};
            e.cnt[k] = 16'(cnt_m[k]);
        end
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ctl%0d", k), 32'(dut_ctl(k)), 32'(e.ctl[k]));
                check($sformatf("cnt%0d", k), 32'(dut_cnt(k)), 32'(e.cnt[k]));
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic sa;
            sa = stall_f(k);
            if (rst) begin
                left[k]  = 0;
                cnt_m[k] = 0;
            end else begin
                if (sa && cnt_m[k] < cmax[k]) cnt_m[k]++;
                if (left[k] > 0) left[k]--;
                else if (haz_f()) left[k] = lsc[k] - 1;
            end
        end
    endtask

    task automatic step(input logic m, input logic [4:0] e,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic u, input logic b, input logic r);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        mr = m; ert = e; rs = s; rt = t; urt = u; br = b; rst = r;
        push_exp();
        @(negedge clk);
        pop_cmp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        mr = 0; ert = 0; rs = 0; rt = 0; urt = 0; br = 0;
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 5, 0, 0, 1, 1);
        idle(2);
        // load-use on rs
        step(1, 5, 5, 0, 0, 0, 0);
        idle(4);
        // rt=0 never stalls, uses_rt gating
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 7, 3, 7, 0, 0, 0);
        idle(3);
        step(1, 7, 3, 7, 1, 0, 0);
        idle(4);
        // branch during stall, then re-asserted
        step(1, 9, 9, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // reset in the second cycle of a 3-cycle stall
        step(1, 4, 2, 4, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            left[k]  = 0;
            cnt_m[k] = 0;
        end
        push_exp();
        #1;
        pop_cmp();
        check("rst_pcw_s3", 32'(hif_s3.pc_write), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // held hazard drives saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) step(1, 6, 6, 0, 0, 0, 0);
        check("sat_final", 32'(hif_sat.stall_cycles), 32'd15);
        idle(4);
        check("sat_hold", 32'(hif_sat.stall_cycles), 32'd15);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, 1), 0);
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
